// File: rtl/downsample_mc.sv
// Multi-channel sample-rate reducer: divides the input strobe rate by a runtime N,
// either picking the first sample of each block or emitting a shifted, saturated block sum.
module downsample_mc #(
    parameter int W  = 18,
    parameter int CH = 2,
    parameter int NW = 4,
    localparam int AW = W + NW,
    localparam int SW = $clog2(W + NW)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NW-1:0]     Nfreq,
    input  logic              mode,
    input  logic [SW-1:0]     shift,
    input  logic              sync,
    input  logic [CH*W-1:0]   datain,
    input  logic              endatain,
    output logic [CH*W-1:0]   dataout,
    output logic              endataout
);

    localparam logic signed [AW-1:0] MAXV = {{(NW+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(NW+1){1'b1}}, {(W-1){1'b0}}};

    logic [NW-1:0]         cnt;
    logic [NW-1:0]         nr;
    logic                  mr;
    logic [SW-1:0]         sr;
    logic signed [AW-1:0]  acc [CH];

    logic                  start;
    logic [NW-1:0]         n_use;
    logic                  m_use;
    logic [SW-1:0]         s_use;
    logic [NW-1:0]         pos;
    logic                  last;
    logic signed [AW-1:0]  xs      [CH];
    logic signed [AW-1:0]  sum_v   [CH];
    logic signed [AW-1:0]  shifted [CH];
    logic [CH*W-1:0]       sat_v;

    // A sync strobe counts as the first sample of a fresh block, so the block
    // parameters come straight from the ports on that strobe.
    always_comb begin
        start = sync | (cnt == '0);
        n_use = nr;
        m_use = mr;
        s_use = sr;
        if (start) begin
            n_use = (Nfreq == '0) ? NW'(1) : Nfreq;
            m_use = mode;
            s_use = shift;
        end
        pos   = start ? '0 : cnt;
        last  = (pos == n_use - NW'(1));
        sat_v = '0;
        for (int k = 0; k < CH; k++) begin
            xs[k]      = AW'($signed(datain[k*W +: W]));
            sum_v[k]   = (pos == '0) ? xs[k] : acc[k] + xs[k];
            shifted[k] = sum_v[k] >>> s_use;
            if (shifted[k] > MAXV)
                sat_v[k*W +: W] = MAXV[W-1:0];
            else if (shifted[k] < MINV)
                sat_v[k*W +: W] = MINV[W-1:0];
            else
                sat_v[k*W +: W] = shifted[k][W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            nr        <= NW'(1);
            mr        <= 1'b0;
            sr        <= '0;
            dataout   <= '0;
            endataout <= 1'b0;
            for (int k = 0; k < CH; k++) acc[k] <= '0;
        end else begin
            endataout <= 1'b0;
            if (endatain) begin
                cnt <= last ? '0 : pos + NW'(1);
                if (start) begin
                    nr <= n_use;
                    mr <= m_use;
                    sr <= s_use;
                end
                for (int k = 0; k < CH; k++) acc[k] <= sum_v[k];
                if (!m_use && pos == '0) begin
                    dataout   <= datain;
                    endataout <= 1'b1;
                end else if (m_use && last) begin
                    dataout   <= sat_v;
                    endataout <= 1'b1;
                end
            end else if (sync) begin
                // partial block is dropped without producing an output
                cnt <= '0;
                for (int k = 0; k < CH; k++) acc[k] <= '0;
            end
        end
    end

endmodule
